apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 52 +++++
 rtl/apb_master.sv | 159 +++++++++++++++
 tb/tb_apb_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
`default_nettype none
//==============================================================================
// Module      : apb_master_if
// Description : Command/response handshake and APB bus bundle for apb_master.
//               The master modport is the apb_master view; the slave modport
//               is the requester-plus-completer view on the other side.
// Revision    : 1.0 - initial release
//==============================================================================
interface apb_master_if #(
    parameter int NSLV = 2
);
    // Requester command channel
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [31:0]     cmd_addr;
    logic [31:0]     cmd_wdata;

    // Requester response channel
    logic            rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;

    // APB request
    logic [NSLV-1:0] PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [31:0]     PADDR;
    logic [31:0]     PWDATA;

    // Muxed APB completer response
    logic [31:0]     PRDATA;
    logic            PREADY;
    logic            PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
//==============================================================================
// Module      : apb_master
// Description : Single-outstanding APB master. Accepts one command at a time,
//               decodes the completer index from the address, runs the
//               SETUP/ACCESS sequence with an optional wait timeout and
//               returns a one-cycle response pulse.
// Revision    : 1.0 - initial release
//==============================================================================
module apb_master #(
    parameter int NSLV    = 2,
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    apb_master_if.master  apb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Counter only ever needs to hold TIMEOUT-1; the abort fires on the edge
    // that would take it to TIMEOUT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t           state_q,     state_d;
    logic [NSLV-1:0]  psel_q,      psel_d;
    logic             penable_q,   penable_d;
    logic             pwrite_q,    pwrite_d;
    logic [31:0]      paddr_q,     paddr_d;
    logic [31:0]      pwdata_q,    pwdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic [3:0]       w_idx;
    logic             w_legal;
    logic [NSLV-1:0]  w_sel;
    logic             w_accept;

    // Completer index decode; out-of-range indices shift the select bit out.
    assign w_idx    = apb.cmd_addr[SEL_LSB+3:SEL_LSB];
    assign w_legal  = ({1'b0, w_idx} < 5'(NSLV));
    assign w_sel    = NSLV'(1) << w_idx;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign apb.cmd_ready = PRESETn && (state_q == IDLE);
    assign w_accept      = apb.cmd_valid && apb.cmd_ready;

    assign apb.PSEL      = psel_q;
    assign apb.PENABLE   = penable_q;
    assign apb.PWRITE    = pwrite_q;
    assign apb.PADDR     = paddr_q;
    assign apb.PWDATA    = pwdata_q;
    assign apb.rsp_valid = rsp_valid_q;
    assign apb.rsp_rdata = rsp_rdata_q;
    assign apb.rsp_err   = rsp_err_q;

    // Next-state logic: sequence IDLE/SETUP/ACCESS and build the response.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        state_d   = SETUP;
                        psel_d    = w_sel;
                        penable_d = 1'b0;
                        paddr_d   = apb.cmd_addr;
                        pwrite_d  = apb.cmd_write;
                        pwdata_d  = apb.cmd_write ? apb.cmd_wdata : 32'h0;
                        cnt_d     = '0;
                    end else begin
                        // Decode error: answer straight away, never touch the bus.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end

            ACCESS: begin
                if (apb.PREADY) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = apb.PSLVERR;
                    rsp_rdata_d = pwrite_q ? 32'h0 : apb.PRDATA;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
//==============================================================================
// Module      : tb_apb_master
// Description : Self-checking bench for apb_master: vector table of transfers
//               with a response scoreboard, plus reset-abort sequences.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_apb_master;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;      // ACCESS cycles with PREADY low before ready
        logic [31:0] prdata;
        logic        slverr;
        logic [1:0]  exp_psel;
        int          exp_acc;    // expected ACCESS length in cycles (0 = no bus)
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic PCLK;
    logic PRESETn;

    apb_master_if #(.NSLV(2)) bus ();

    apb_master #(
        .NSLV    (2),
        .SEL_LSB (28),
        .TIMEOUT (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t sb[$];
    vec_t vecs[8];

    logic        last_err;
    logic [31:0] last_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: pop scoreboard on each pulse, check hold otherwise.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            last_err   <= 1'b0;
            last_rdata <= 32'h0;
        end else if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            end
            last_err   <= bus.rsp_err;
            last_rdata <= bus.rsp_rdata;
        end else begin
            chk("rsp_err_hold", 32'(bus.rsp_err), 32'(last_err));
            chk("rsp_rdata_hold", bus.rsp_rdata, last_rdata);
        end
    end

    // Run one command from a negedge; returns at the negedge where rsp_valid is high.
    task automatic do_xfer(input vec_t v);
        int   n;
        int   acc;
        rsp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'h1);
            bus.cmd_valid = 1'b0;
            return;
        end
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        sb.push_back(e);
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 32'h5555_AAAA;   // must not leak into PWDATA
        if (v.exp_acc == 0) begin
            chk("decode_psel", 32'(bus.PSEL), 32'h0);
            chk("decode_penable", 32'(bus.PENABLE), 32'h0);
        end else begin
            chk("setup_psel", 32'(bus.PSEL), 32'(v.exp_psel));
            chk("setup_penable", 32'(bus.PENABLE), 32'h0);
            chk("setup_paddr", bus.PADDR, v.addr);
            chk("setup_pwrite", 32'(bus.PWRITE), 32'(v.wr));
            chk("setup_pwdata", bus.PWDATA, v.wr ? v.wdata : 32'h0);
            chk("setup_cmd_ready", 32'(bus.cmd_ready), 32'h0);
            @(negedge PCLK);
            chk("access_penable", 32'(bus.PENABLE), 32'h1);
            acc = 1;
            for (int k = 0; k < 40; k++) begin
                if (acc > v.waits) begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = v.prdata;
                    bus.PSLVERR = v.slverr;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = 32'hDEAD_0000 + 32'(acc);
                    bus.PSLVERR = 1'b1;
                end
                @(negedge PCLK);
                if (!bus.PENABLE) break;
                acc++;
                chk("access_psel_hold", 32'(bus.PSEL), 32'(v.exp_psel));
                chk("access_paddr_hold", bus.PADDR, v.addr);
            end
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b1;
            bus.PRDATA  = 32'hBAD0_BAD0;
            chk("access_len", 32'(acc), 32'(v.exp_acc));
            chk("idle_psel", 32'(bus.PSEL), 32'h0);
            chk("idle_paddr_hold", bus.PADDR, v.addr);
        end
        chk("rsp_valid_pulse", 32'(bus.rsp_valid), 32'h1);
        chk("ready_with_rsp", 32'(bus.cmd_ready), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr    addr          wdata          waits prdata         err   psel   acc err   rdata
        vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0,   32'hFFFF_FFFF, 1'b0, 2'b01, 1,  1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h1000_0008, 32'h0,         3,   32'h1234_5678, 1'b0, 2'b10, 4,  1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         0,   32'hCAFE_F00D, 1'b1, 2'b01, 1,  1'b1, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 32'h3000_0000, 32'h1111_2222, 0,   32'h0,         1'b0, 2'b00, 0,  1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h1000_0000, 32'h0,         100, 32'h7777_7777, 1'b0, 2'b10, 16, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'h1FFF_FFFC, 32'h0BAD_F00D, 2,   32'h9999_9999, 1'b1, 2'b10, 3,  1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'h2000_0000, 32'h0,         0,   32'h0,         1'b0, 2'b00, 0,  1'b1, 32'h0};
        vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         15,  32'hA5A5_5A5A, 1'b0, 2'b01, 16, 1'b0, 32'hA5A5_5A5A};

        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.PRDATA    = 32'h0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        chk("rst_psel", 32'(bus.PSEL), 32'h0);
        chk("rst_penable", 32'(bus.PENABLE), 32'h0);
        chk("rst_pwrite", 32'(bus.PWRITE), 32'h0);
        chk("rst_paddr", bus.PADDR, 32'h0);
        chk("rst_pwdata", bus.PWDATA, 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        PRESETn = 1'b1;
        #1;
        chk("release_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        @(negedge PCLK);

        // Table: back-to-back, each command offered in the previous rsp_valid cycle
        for (int i = 0; i < 8; i++) begin
            do_xfer(vecs[i]);
        end
        @(negedge PCLK);

        // Reset in the middle of ACCESS aborts silently
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h1000_0000;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        chk("abort_setup_psel", 32'(bus.PSEL), 32'h2);
        @(negedge PCLK);
        chk("abort_access_penable", 32'(bus.PENABLE), 32'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("abort_async_psel", 32'(bus.PSEL), 32'h0);
        chk("abort_async_penable", 32'(bus.PENABLE), 32'h0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("abort_paddr", bus.PADDR, 32'h0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk("abort_release_ready", 32'(bus.cmd_ready), 32'h1);
        repeat (3) @(negedge PCLK);

        // Reset during SETUP also aborts
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h0000_0020;
        bus.cmd_wdata = 32'h0F0F_0F0F;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        chk("abort2_setup_psel", 32'(bus.PSEL), 32'h1);
        PRESETn = 1'b0;
        #1;
        chk("abort2_psel", 32'(bus.PSEL), 32'h0);
        chk("abort2_pwdata", bus.PWDATA, 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        // Recovery after reset
        do_xfer(vecs[0]);
        repeat (3) @(negedge PCLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
